lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the ALU in the mvp-0 core.
- For isLoad/isStore instructions it takes the ALU result Q as the byte address, func3 as the access size, and rs2 as store data.
- It runs one memory transaction over a valid/ready data-memory port and returns the aligned, sign/zero-extended load result for writeback.
- Multi-cycle: the core control FSM holds off writeback until done.

---
 rtl/lsu_mem_stage.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit, one data-memory transaction per accepted start.
// Latency: done 2+k cycles after start (k = mem_ready wait cycles); illegal/trapped accesses finish after 1.
// Backpressure: mem_req held with stable addr/wmask/wdata until mem_ready; aborts after TIMEOUT_CYCLES (0 = never).
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.

module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // Counter value in the last ACCESS cycle allowed before the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_ok;
    logic              f3_legal;
    logic              misalign;
    logic [3:0]        st_mask;
    logic [31:0]       st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;

    assign req_ok = start && (isLoad ^ isStore);

    // Decode which func3 values are legal for the requested access type.
    always_comb begin
        f3_legal = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = isLoad;
            default:                f3_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                      ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    // Without trapping, the low address bits below the access size are simply ignored.
    assign misalign = 1'b0;
`endif

    // Build store byte enables and lane-replicated store data from the request.
    always_comb begin
        st_mask = 4'b1111;
        st_data = wdata;
        case (func3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_mask = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the read word and extend it.
    always_comb begin
        case (off_q)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (func3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ready or timeout in ACCESS, pulse DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        func3_d   = func3_q;
        off_d     = off_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    if (!f3_legal || misalign) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_ACCESS;
                        cnt_d     = '0;
                        is_load_d = isLoad;
                        func3_d   = func3;
                        off_d     = addr[1:0];
                        addr_d    = {addr[31:2], 2'b00};
                        wdata_d   = st_data;
                        wmask_d   = isLoad ? 4'b0000 : st_mask;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (is_load_q) begin
                        rdata_d = ld_val;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            func3_q   <= 3'b000;
            off_q     <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= 4'b0000;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            func3_q   <= func3_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign busy      = (state_q == S_ACCESS);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state_q == S_ACCESS);
    assign mem_rstrb = (state_q == S_ACCESS) && is_load_q;
    assign mem_wmask = (state_q == S_ACCESS) ? wmask_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        isLoad;
    logic        isStore;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] mdl_rdata = 32'd0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .isLoad    (isLoad),
        .isStore   (isStore),
        .func3     (func3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // One access: inputs, memory wait k, and what must be observed.
    typedef struct {
        string       nm;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          k;
        bit          noise;   // drive extra starts while busy and in the done cycle
        logic        acc;     // request is accepted at all
        logic        imm;     // finishes straight away without a memory request
        int          req_cyc;
        logic [31:0] e_maddr;
        logic [3:0]  e_wmask;
        logic [31:0] e_wdata;
        logic        e_err;
        int          rdm;     // 0: rdata not checked, 1: e_rdata, 2: unchanged
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t tv(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                                input int k, input bit noise, input logic acc, input logic imm,
                                input int rc, input logic [31:0] maddr, input logic [3:0] wm,
                                input logic [31:0] ewd, input logic e_err, input int rdm,
                                input logic [31:0] erd);
        vec_t v;
        v.nm = nm; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.mrd = mrd;
        v.k = k; v.noise = noise; v.acc = acc; v.imm = imm; v.req_cyc = rc;
        v.e_maddr = maddr; v.e_wmask = wm; v.e_wdata = ewd; v.e_err = e_err;
        v.rdm = rdm; v.e_rdata = erd;
        return v;
    endfunction

    // Reference model: derives the expected outcome from access size and byte offset arithmetic.
    function automatic vec_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] mrd, input int k, input bit noise);
        vec_t   v;
        bit     legal;
        bit     mis;
        int     nb;
        int     off;
        int     eff;
        longint val;
        v.nm = "rnd"; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.mrd = mrd; v.k = k;
        v.acc   = ld ^ st;
        v.noise = noise && v.acc;
        legal   = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        nb      = 1 << f3[1:0];
        off     = int'(a[1:0]);
        eff     = (off / nb) * nb;
        mis     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis     = (off % nb) != 0;
`endif
        v.imm     = !legal || mis;
        v.req_cyc = (k < TO) ? k + 1 : TO;
        v.e_maddr = a & 32'hFFFF_FFFC;
        v.e_wmask = st ? 4'(((1 << nb) - 1) << eff) : 4'b0000;
        for (int i = 0; i < 4; i++) begin
            v.e_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        v.e_err   = v.imm || (k >= TO);
        v.rdm     = 0;
        v.e_rdata = 32'd0;
        if (v.imm) begin
            v.rdm = mis ? 2 : 0;
        end else if (k >= TO) begin
            v.rdm = 1;
        end else if (ld) begin
            val = (longint'(mrd) >> (8 * eff)) & ((64'd1 << (8 * nb)) - 1);
            if (!f3[2] && nb < 4 && val[8*nb-1]) begin
                val = val - (64'd1 << (8 * nb));
            end
            v.rdm     = 1;
            v.e_rdata = val[31:0];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h at t=%0t", tag, what, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_vec(input vec_t v);
        start = 1'b1; isLoad = v.ld; isStore = v.st; func3 = v.f3;
        addr = v.addr; wdata = v.wd; mem_rdata = v.mrd; mem_ready = 1'b0;
        @(negedge clk);
        if (v.noise) begin
            start = 1'b1; isLoad = 1'b1; isStore = 1'b0; func3 = 3'b010;
            addr = $urandom; wdata = $urandom;
        end else begin
            start = 1'b0; addr = $urandom; wdata = $urandom; func3 = 3'($urandom);
        end
        if (!v.acc) begin
            repeat (3) begin
                chk(v.nm, "ign_busy", busy, 1'b0);
                chk(v.nm, "ign_done", done, 1'b0);
                chk(v.nm, "ign_req", mem_req, 1'b0);
                @(negedge clk);
            end
            return;
        end
        if (v.imm) begin
            chk(v.nm, "imm_done", done, 1'b1);
            chk(v.nm, "imm_err", err, 1'b1);
            chk(v.nm, "imm_req", mem_req, 1'b0);
            chk(v.nm, "imm_busy", busy, 1'b0);
            if (v.rdm == 2) chk(v.nm, "imm_rdata", rdata, mdl_rdata);
        end else begin
            for (int i = 0; i < v.req_cyc; i++) begin
                chk(v.nm, "req", mem_req, 1'b1);
                chk(v.nm, "busy", busy, 1'b1);
                chk(v.nm, "early_done", done, 1'b0);
                chk(v.nm, "mem_addr", mem_addr, v.e_maddr);
                chk(v.nm, "mem_wmask", mem_wmask, v.e_wmask);
                chk(v.nm, "mem_rstrb", mem_rstrb, v.ld);
                if (v.st) chk(v.nm, "mem_wdata", mem_wdata, v.e_wdata);
                mem_ready = (i == v.k);
                @(negedge clk);
                mem_ready = 1'b0;
            end
            chk(v.nm, "done", done, 1'b1);
            chk(v.nm, "err", err, v.e_err);
            chk(v.nm, "done_busy", busy, 1'b0);
            chk(v.nm, "done_req", mem_req, 1'b0);
            if (v.rdm == 1) begin
                chk(v.nm, "rdata", rdata, v.e_rdata);
                mdl_rdata = v.e_rdata;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk(v.nm, "post_done", done, 1'b0);
        chk(v.nm, "post_busy", busy, 1'b0);
        chk(v.nm, "post_req", mem_req, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, "busy", busy, 1'b0);
        chk(tag, "done", done, 1'b0);
        chk(tag, "err", err, 1'b0);
        chk(tag, "rdata", rdata, 32'd0);
        chk(tag, "mem_req", mem_req, 1'b0);
        chk(tag, "mem_rstrb", mem_rstrb, 1'b0);
        chk(tag, "mem_wmask", mem_wmask, 4'b0000);
        chk(tag, "mem_addr", mem_addr, 32'd0);
        chk(tag, "mem_wdata", mem_wdata, 32'd0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        tbl.push_back(tv("lb_neg",   1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h8A00_0000, 0, 0,
                         1, 0, 1, 32'h0000_1000, 4'h0, 32'h0, 0, 1, 32'hFFFF_FF8A));
        tbl.push_back(tv("lbu",      1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h8A00_0000, 0, 0,
                         1, 0, 1, 32'h0000_1000, 4'h0, 32'h0, 0, 1, 32'h0000_008A));
        tbl.push_back(tv("sh_wait3", 0, 1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 3, 0,
                         1, 0, 4, 32'h0000_2000, 4'hC, 32'hBEEF_BEEF, 0, 0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back(tv("lw_mis",   1, 0, 3'b010, 32'h0000_1001, 32'h0, 32'hCAFE_F00D, 1, 0,
                         1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 2, 32'h0));
`else
        tbl.push_back(tv("lw_mis",   1, 0, 3'b010, 32'h0000_1001, 32'h0, 32'hCAFE_F00D, 1, 0,
                         1, 0, 2, 32'h0000_1000, 4'h0, 32'h0, 0, 1, 32'hCAFE_F00D));
`endif
        tbl.push_back(tv("sw_tmo",   0, 1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 9, 1,
                         1, 0, 4, 32'h0000_3000, 4'hF, 32'hDEAD_BEEF, 1, 1, 32'h0));
        tbl.push_back(tv("lh_hi",    1, 0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 0, 0,
                         1, 0, 1, 32'h0000_4000, 4'h0, 32'h0, 0, 1, 32'hFFFF_8001));
        tbl.push_back(tv("lhu_lo",   1, 0, 3'b101, 32'h0000_4000, 32'h0, 32'h8001_7FFF, 2, 1,
                         1, 0, 3, 32'h0000_4000, 4'h0, 32'h0, 0, 1, 32'h0000_7FFF));
        tbl.push_back(tv("sb_off1",  0, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 0, 0,
                         1, 0, 1, 32'h0000_5000, 4'h2, 32'hA5A5_A5A5, 0, 0, 32'h0));
        tbl.push_back(tv("ld_f3_011", 1, 0, 3'b011, 32'h0000_6000, 32'h0, 32'h0, 0, 0,
                         1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0));
        tbl.push_back(tv("st_f3_100", 0, 1, 3'b100, 32'h0000_6000, 32'h0, 32'h0, 0, 1,
                         1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0));
        tbl.push_back(tv("both_set", 1, 1, 3'b000, 32'h0000_6000, 32'h0, 32'h0, 0, 0,
                         0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(tv("none_set", 0, 0, 3'b010, 32'h0000_6000, 32'h0, 32'h0, 0, 0,
                         0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(tv("lb_tmo",   1, 0, 3'b000, 32'h0000_6000, 32'h0, 32'h0000_007F, 4, 1,
                         1, 0, 4, 32'h0000_6000, 4'h0, 32'h0, 1, 1, 32'h0));
        tbl.push_back(tv("sw_after", 0, 1, 3'b010, 32'h0000_7004, 32'h0BAD_CAFE, 32'h0, 0, 0,
                         1, 0, 1, 32'h0000_7004, 4'hF, 32'h0BAD_CAFE, 0, 0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back(tv("lh_odd",   1, 0, 3'b001, 32'h0000_4003, 32'h0, 32'h8001_7FFF, 0, 0,
                         1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 2, 32'h0));
`else
        tbl.push_back(tv("lh_odd",   1, 0, 3'b001, 32'h0000_4003, 32'h0, 32'h8001_7FFF, 0, 0,
                         1, 0, 1, 32'h0000_4000, 4'h0, 32'h0, 0, 1, 32'hFFFF_8001));
`endif

        rst_n = 1'b0; start = 1'b0; isLoad = 1'b0; isStore = 1'b0; func3 = 3'b000;
        addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // Reset two cycles into an access: everything clears, no done follows.
        start = 1'b1; isLoad = 1'b1; isStore = 1'b0; func3 = 3'b010;
        addr = 32'h0000_8008; mem_rdata = 32'h1111_2222; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("rst_mid", "req_before", mem_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rst_mid");
        mdl_rdata = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid", "no_done", done, 1'b0);
            chk("rst_mid", "no_busy", busy, 1'b0);
        end
        // The timeout counter must restart from zero after the reset.
        run_vec(model(1'b0, 1'b1, 3'b010, 32'h0000_9000, 32'h5555_AAAA, 32'h0, 7, 1'b0));

        for (int n = 0; n < 200; n++) begin
            int  r;
            logic ld;
            logic st;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                ld = 1'b1; st = 1'b0;
            end else if (r < 9) begin
                ld = 1'b0; st = 1'b1;
            end else begin
                ld = 1'($urandom); st = ld;
            end
            v = model(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
            run_vec(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
